// File: rtl/sreg_defs.sv
// Shared definitions for the serial shift-register family (PISO / SIPO).
package sreg_defs;

    // State encodings shared by the serializer and deserializer FSMs.
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    // Bit-order selectors for the MSB_FIRST parameter.
    localparam int unsigned SHIFT_MSB_FIRST = 1;
    localparam int unsigned SHIFT_LSB_FIRST = 0;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

    // Width of a counter that indexes the bits of a word (at least 1 bit).
    function automatic int unsigned bit_cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the PISO serializer; flags the final bit of a word.
module piso_bit_counter
    import sreg_defs::*;
#(
    parameter int unsigned WIDTH = 3,
    localparam int unsigned CW   = bit_cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          at_last
);

    // Count transmitted bits; clear has priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Final bit position of the word.
    always_comb begin
        at_last = (cnt == CW'(WIDTH - 1));
    end

endmodule

// File: rtl/positive_triggered_piso_serializer.sv
// Parallel-in serial-out serializer with load/ready handshake and framing strobes.
module positive_triggered_piso_serializer
    import sreg_defs::*;
#(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned MSB_FIRST = SHIFT_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             last
);

    localparam int unsigned CW      = bit_cnt_width(WIDTH);
    localparam int unsigned OUT_IDX = (MSB_FIRST == SHIFT_MSB_FIRST) ? WIDTH - 1 : 0;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             cnt_clear;
    logic             cnt_en;
    logic             accept;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .cnt     (cnt),
        .at_last (at_last)
    );

    // Handshake and strobes decode registered state only.
    always_comb begin
        q_valid = (state == SHIFT);
        last    = (state == SHIFT) && at_last;
        ready   = (state == IDLE) || last;
        accept  = load && ready;
        q       = (state == SHIFT) ? shreg[OUT_IDX] : 1'b0;
    end

    // Next state, shift-register update and counter control.
    // The counter is also cleared when the word ends without a reload, so
    // IDLE always holds cnt at 0 rather than a wrapped value.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        if (accept) begin
            shreg_nxt = din;
            cnt_clear = 1'b1;
            state_nxt = SHIFT;
        end else if (state == SHIFT) begin
            if (MSB_FIRST == SHIFT_MSB_FIRST) begin
                shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
            end
            if (at_last) begin
                state_nxt = IDLE;
                cnt_clear = 1'b1;
            end else begin
                cnt_en = 1'b1;
            end
        end
    end

    // State and shift-register storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
        end
    end

endmodule
